// File: rtl/moka_rv32i_trace_buffer.sv
// Retirement trace capture: circular buffer of per-retire records, continuous or PC-triggered, streamed oldest-first.
// Optional MOKA_TRACE_TIMESTAMP_EN stores a free-running cycle stamp in each record's MSBs. Read path is combinational from DONE.
module moka_rv32i_trace_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int TS_WIDTH   = 16,
    localparam int ADDR_W    = $clog2(DEPTH),
`ifdef MOKA_TRACE_TIMESTAMP_EN
    localparam int REC_W     = 3*DATA_WIDTH + 8 + TS_WIDTH
`else
    localparam int REC_W     = 3*DATA_WIDTH + 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_mode,
    input  logic [DATA_WIDTH-1:0] cfg_trig_pc,
    input  logic [ADDR_W:0]       cfg_post,
    input  logic                  arm,
    input  logic                  stop,
    input  logic                  retire,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic [4:0]            rd,
    input  logic                  RegWrite,
    input  logic                  MemWrite,
    input  logic                  PCSrc,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [REC_W-1:0]      rd_data,
    output logic [ADDR_W:0]       count,
    output logic                  busy,
    output logic                  done,
    output logic                  triggered,
    output logic                  overflow
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, POST, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   post_cnt;
    logic [REC_W-1:0]  mem [DEPTH];
    logic [REC_W-1:0]  rec;
    logic              trig_hit, wr_en, pop;

    assign trig_hit = retire && (pc == cfg_trig_pc);
    assign wr_en    = retire && !arm && (state == CAPTURE || state == POST);
    assign pop      = rd_valid && rd_ready;

`ifdef MOKA_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else     ts <= ts + TS_WIDTH'(1);
    end

    assign rec = {ts, PCSrc, MemWrite, RegWrite, rd, WD3, instruction, pc};
`else
    assign rec = {PCSrc, MemWrite, RegWrite, rd, WD3, instruction, pc};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // arm wins over stop and over any trigger/post event in the same cycle
    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = CAPTURE;
        end else begin
            case (state)
                CAPTURE: begin
                    if (stop)
                        state_nxt = DONE;
                    else if (cfg_mode && trig_hit)
                        state_nxt = (cfg_post == '0) ? DONE : POST;
                end
                POST: begin
                    if (stop || (retire && post_cnt == CNT_W'(1)))
                        state_nxt = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else if (arm) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                // full buffer: drop the oldest record rather than the newest
                if (count == FULL) begin
                    overflow <= 1'b1;
                    rd_ptr   <= rd_ptr + ADDR_W'(1);
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
            if (state == CAPTURE && cfg_mode && trig_hit) begin
                triggered <= 1'b1;
                post_cnt  <= cfg_post;
            end else if (state == POST && retire) begin
                post_cnt <= post_cnt - CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                count  <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rec;
    end

    assign rd_valid = (state == DONE) && (count != '0);
    assign rd_data  = (state == DONE) ? mem[rd_ptr] : '0;
    assign busy     = (state == CAPTURE) || (state == POST);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_moka_rv32i_trace_buffer.sv
// Directed bench for moka_rv32i_trace_buffer: reset, continuous/overflow, triggered, backpressure, reset in POST.
// With MOKA_TRACE_TIMESTAMP_EN the DUT runs with a 4-bit stamp so the wrap is reachable quickly.
module tb_moka_rv32i_trace_buffer;

    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int TSW = 4;
`ifdef MOKA_TRACE_TIMESTAMP_EN
    localparam int REC_W = 3*DW + 8 + TSW;
`else
    localparam int REC_W = 3*DW + 8;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_mode;
    logic [DW-1:0]    cfg_trig_pc;
    logic [4:0]       cfg_post;
    logic             arm, stop, retire;
    logic [DW-1:0]    pc, instruction, WD3;
    logic [4:0]       rd;
    logic             RegWrite, MemWrite, PCSrc;
    logic             rd_valid, rd_ready;
    logic [REC_W-1:0] rd_data;
    logic [4:0]       count;
    logic             busy, done, triggered, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    moka_rv32i_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_trig_pc(cfg_trig_pc), .cfg_post(cfg_post),
        .arm(arm), .stop(stop), .retire(retire), .pc(pc), .instruction(instruction), .WD3(WD3),
        .rd(rd), .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrc(PCSrc),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
        .busy(busy), .done(done), .triggered(triggered), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [103:0] mkrec(input logic [31:0] p);
        logic [31:0] w;
        w = p + 32'h100;
        return {p[2], p[3], p[4], p[6:2], w, ~p, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_retire(input logic [31:0] p);
        retire = 1'b1; pc = p; instruction = ~p; WD3 = p + 32'h100;
        rd = p[6:2]; RegWrite = p[4]; MemWrite = p[3]; PCSrc = p[2];
        tick();
        retire = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".rd_valid"}, rd_valid, 1'b0);
        check({tag, ".count"}, count, 5'd0);
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".done"}, done, 1'b0);
        check({tag, ".triggered"}, triggered, 1'b0);
        check({tag, ".overflow"}, overflow, 1'b0);
        check({tag, ".rd_data"}, rd_data, '0);
    endtask

    task automatic read_all(input string tag, input int n, input logic [31:0] first_pc);
        rd_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.vld%0d", tag, i), rd_valid, 1'b1);
            check($sformatf("%s.pc%0d", tag, i), rd_data[31:0], first_pc + 32'(4*i));
            tick();
        end
        rd_ready = 1'b0;
        check({tag, ".empty_vld"}, rd_valid, 1'b0);
        check({tag, ".empty_cnt"}, count, 5'd0);
        check({tag, ".still_done"}, done, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;
        rst = 1'b1; cfg_mode = 1'b0; cfg_trig_pc = '0; cfg_post = '0;
        arm = 1'b0; stop = 1'b0; retire = 1'b0; rd_ready = 1'b0;
        pc = '0; instruction = '0; WD3 = '0; rd = '0;
        RegWrite = 1'b0; MemWrite = 1'b0; PCSrc = 1'b0;
        #12;
        check_idle_outputs("por");
        tick();
        rst = 1'b0;

        // mid-clock reset after some activity
        pulse_arm();
        for (int i = 0; i < 3; i++) do_retire(32'(4*i));
        check("pre_rst.count", count, 5'd3);
        #3 rst = 1'b1;
        #1 check_idle_outputs("async_rst");
        tick();
        rst = 1'b0;

        // continuous with overflow
        cfg_mode = 1'b0;
        pulse_arm();
        check("cont.busy", busy, 1'b1);
        for (int i = 0; i < 20; i++) do_retire(32'(4*i));
        pulse_stop();
        check("cont.count", count, 5'd16);
        check("cont.overflow", overflow, 1'b1);
        check("cont.done", done, 1'b1);
        check("cont.busy", busy, 1'b0);
        check("cont.rec0", rd_data[103:0], mkrec(32'h10));
        read_all("cont", 16, 32'h10);

        // triggered, post = 3
        cfg_mode = 1'b1; cfg_trig_pc = 32'h20; cfg_post = 5'd3;
        pulse_arm();
        check("trig.rearm_cnt", count, 5'd0);
        for (int i = 0; i < 9; i++) do_retire(32'(4*i));
        check("trig.post_busy", busy, 1'b1);
        check("trig.flag", triggered, 1'b1);
        for (int i = 9; i < 12; i++) do_retire(32'(4*i));
        check("trig.done", done, 1'b1);
        check("trig.count", count, 5'd12);
        check("trig.overflow", overflow, 1'b0);
        for (int i = 12; i < 16; i++) do_retire(32'(4*i));
        check("trig.ignored_cnt", count, 5'd12);
        read_all("trig", 12, 32'h0);

        // backpressure with ready pattern 1,0,0 repeating
        cfg_mode = 1'b0;
        pulse_arm();
        for (int i = 0; i < 16; i++) do_retire(32'h100 + 32'(4*i));
        pulse_stop();
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 200) begin
            rd_ready = (cyc % 3 == 0);
            check($sformatf("bp.vld%0d", cyc), rd_valid, 1'b1);
            check($sformatf("bp.pc%0d", cyc), rd_data[31:0], 32'h100 + 32'(4*idx));
            if (rd_ready && rd_valid) idx++;
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        check("bp.pops", idx, 16);
        check("bp.final_vld", rd_valid, 1'b0);
        check("bp.final_cnt", count, 5'd0);

        // reset while in POST
        cfg_mode = 1'b1; cfg_trig_pc = 32'h20; cfg_post = 5'd5;
        pulse_arm();
        for (int i = 0; i < 11; i++) do_retire(32'(4*i));
        check("post.busy", busy, 1'b1);
        check("post.count", count, 5'd11);
        #3 rst = 1'b1;
        #1 check_idle_outputs("post_rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) do_retire(32'(4*i));
        check_idle_outputs("post_rst_ignored");
        pulse_arm();
        do_retire(32'h0);
        check("rearm.count", count, 5'd1);

`ifdef MOKA_TRACE_TIMESTAMP_EN
        begin
            logic [TSW-1:0] prev_ts;
            logic [TSW-1:0] cur_ts;
            logic [TSW-1:0] step;
            logic           wrapped;
            cfg_mode = 1'b0;
            pulse_arm();
            for (int i = 0; i < 8; i++) begin
                do_retire(32'h200 + 32'(4*i));
                tick();
                tick();
            end
            pulse_stop();
            check("ts.count", count, 5'd8);
            rd_ready = 1'b1;
            wrapped = 1'b0;
            prev_ts = rd_data[REC_W-1 -: TSW];
            tick();
            for (int i = 1; i < 8; i++) begin
                cur_ts = rd_data[REC_W-1 -: TSW];
                step = cur_ts - prev_ts;
                check($sformatf("ts.step%0d", i), step, TSW'(3));
                if (cur_ts < prev_ts) wrapped = 1'b1;
                prev_ts = cur_ts;
                tick();
            end
            rd_ready = 1'b0;
            check("ts.wrap_seen", wrapped, 1'b1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
